// File: rtl/dma_descriptor_dispatcher.sv
// Descriptor scheduler: queues host descriptors and runs them one at a time through the
// read and write engines, counting completions and halting on engine errors.
module dma_descriptor_dispatcher #(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned LENGTH_W   = 24,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          desc_valid,
    output logic                          desc_ready,
    input  logic [ADDR_W-1:0]             desc_src_addr,
    input  logic [ADDR_W-1:0]             desc_dest_addr,
    input  logic [LENGTH_W-1:0]           desc_length,
    input  logic [1:0]                    desc_mode,
    output logic [ADDR_W-1:0]             cur_src_addr,
    output logic [ADDR_W-1:0]             cur_dest_addr,
    output logic [LENGTH_W-1:0]           cur_length,
    output logic [1:0]                    cur_mode,
    output logic                          rd_go,
    output logic                          wr_go,
    input  logic                          rd_done,
    input  logic                          wr_done,
    input  logic                          rd_err,
    input  logic                          wr_err,
    input  logic                          reset_dispatcher,
    output logic                          busy,
    output logic                          stopped_on_error,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [CNT_W-1:0]              completed_cnt,
    output logic                          irq
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [4:0] {
        StIdle     = 5'b00001,
        StLoad     = 5'b00010,
        StRun      = 5'b00100,
        StComplete = 5'b01000,
        StError    = 5'b10000
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0]   src_mem  [FIFO_DEPTH];
    logic [ADDR_W-1:0]   dest_mem [FIFO_DEPTH];
    logic [LENGTH_W-1:0] len_mem  [FIFO_DEPTH];
    logic [1:0]          mode_mem [FIFO_DEPTH];

    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                rd_seen_q, rd_seen_d, wr_seen_q, wr_seen_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   cur_src_q, cur_dest_q;
    logic [LENGTH_W-1:0] cur_len_q;
    logic [1:0]          cur_mode_q;

    logic push, pop, skip, err;

    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (level_q == '0);
    assign desc_ready = !fifo_full && (state_q != StError);

    // A software clear drops any push or pop landing in the same cycle.
    assign push = desc_valid && desc_ready && !reset_dispatcher;
    assign pop  = (state_q == StIdle) && !fifo_empty && !reset_dispatcher;
    assign skip = (cur_len_q == '0) || (cur_mode_q == 2'd0);
    assign err  = rd_err || wr_err;

    always_comb begin
        state_d   = state_q;
        rd_seen_d = rd_seen_q;
        wr_seen_d = wr_seen_q;
        unique case (state_q)
            StIdle:     if (!fifo_empty) state_d = StLoad;
            StLoad: begin
                rd_seen_d = 1'b0;
                wr_seen_d = 1'b0;
                if (err)       state_d = StError;
                else if (skip) state_d = StComplete;
                else           state_d = StRun;
            end
            StRun: begin
                rd_seen_d = rd_seen_q || rd_done;
                wr_seen_d = wr_seen_q || wr_done;
                if (err) state_d = StError;
                else if ((rd_seen_q || rd_done) && (wr_seen_q || wr_done)) state_d = StComplete;
            end
            StComplete: state_d = StIdle;
            StError:    state_d = StError;
            default:    state_d = StIdle;
        endcase
        if (reset_dispatcher) begin
            state_d   = StIdle;
            rd_seen_d = 1'b0;
            wr_seen_d = 1'b0;
        end
    end

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        if (reset_dispatcher) level_d = '0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            src_mem[wr_ptr_q]  <= desc_src_addr;
            dest_mem[wr_ptr_q] <= desc_dest_addr;
            len_mem[wr_ptr_q]  <= desc_length;
            mode_mem[wr_ptr_q] <= desc_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_seen_q  <= 1'b0;
            wr_seen_q  <= 1'b0;
            cnt_q      <= '0;
            cur_src_q  <= '0;
            cur_dest_q <= '0;
            cur_len_q  <= '0;
            cur_mode_q <= '0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            rd_seen_q <= rd_seen_d;
            wr_seen_q <= wr_seen_d;
            if (reset_dispatcher) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (pop) begin
                cur_src_q  <= src_mem[rd_ptr_q];
                cur_dest_q <= dest_mem[rd_ptr_q];
                cur_len_q  <= len_mem[rd_ptr_q];
                cur_mode_q <= mode_mem[rd_ptr_q];
            end
            // Count on entry so the new value is visible alongside irq.
            if (state_d == StComplete) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cur_src_addr     = cur_src_q;
    assign cur_dest_addr    = cur_dest_q;
    assign cur_length       = cur_len_q;
    assign cur_mode         = cur_mode_q;
    assign rd_go            = (state_q == StLoad) && !skip;
    assign wr_go            = (state_q == StLoad) && !skip;
    assign busy             = (state_q != StIdle);
    assign stopped_on_error = (state_q == StError);
    assign irq              = (state_q == StComplete);
    assign fifo_level       = level_q;
    assign completed_cnt    = cnt_q;

endmodule
